fir_mem_arbiter: RTL and testbench

- Shares the FIR sample memory (port A read, port B write) between three requesters: 0 = sample loader/host, 1 = non-pipelined FIR, 2 = pipelined FIR.
- Sits between the requesters and the dual-port sample RAM, replacing direct and forced port drive.
- Round-robin grant with bus lock, a max-hold limit, a one-cycle handover bubble so registered reads drain, and usage counters for performance comparison.

---
 rtl/fir_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_fir_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mem_arbiter.sv
// fir_mem_arbiter
// Shares the dual-port FIR sample RAM (port A read, port B write) between
// three requesters: 0 = sample loader/host, 1 = non-pipelined FIR,
// 2 = pipelined FIR. Round-robin arbitration with bus lock, an optional
// max-hold limit, a one-cycle handover bubble so registered reads drain,
// and saturating usage counters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[2:0]          per-requester access request
//   gnt[2:0]          registered one-hot grant
//   rd_addr/wr_addr   packed per-requester addresses (slice i = requester i)
//   wr_en, wr_data    per-requester write enable / packed write data
//   rd_data           RAM read data broadcast to all requesters
//   rd_valid[2:0]     one-hot, rd_data is valid for requester i
//   mem_*             RAM port A (read) and port B (write) connections
//   busy_cycles       cycles with a grant active (saturating)
//   stall_cycles      cycles with a request waiting without grant (saturating)
module fir_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  output logic [2:0]          gnt,
  input  logic [3*ADDR_W-1:0] rd_addr,
  input  logic [3*ADDR_W-1:0] wr_addr,
  input  logic [2:0]          wr_en,
  input  logic [3*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic [2:0]          rd_valid,
  output logic [ADDR_W-1:0]   mem_addr_a,
  input  logic [DATA_W-1:0]   mem_data_out_a,
  output logic [ADDR_W-1:0]   mem_addr_b,
  output logic                mem_we_b,
  output logic [DATA_W-1:0]   mem_data_in_b,
  output logic [CNT_W-1:0]    busy_cycles,
  output logic [CNT_W-1:0]    stall_cycles
);

  // Hold counter only needs to reach MAX_HOLD-1; it saturates there so a
  // long solo grant releases as soon as someone else starts waiting.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t            state, state_n;
  logic [2:0]        gnt_n;
  logic [1:0]        last, last_n;
  logic [1:0]        pick;
  logic [HOLD_W-1:0] hold, hold_n;
  logic              win_req;
  logic              others_pending;
  logic              force_release;

  assign win_req        = |(req & gnt);
  assign others_pending = |(req & ~gnt);
  assign force_release  = (MAX_HOLD != 0) && (hold == HOLD_LAST) && others_pending;

  // First requesting index after the previous winner, in modulo-3 order.
  // Only meaningful when req is non-zero.
  always_comb begin
    pick = 2'd0;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Next-state logic. A grant ends when its owner drops req, or when the
  // hold limit is hit while another requester waits; either way a HANDOVER
  // cycle follows so the last registered read returns before re-arbitration.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    hold_n  = hold;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = 3'b001 << pick;
          last_n  = pick;
          hold_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (hold != HOLD_LAST) hold_n = hold + HOLD_W'(1);
        if (!win_req || force_release) begin
          gnt_n   = '0;
          state_n = HANDOVER;
        end
      end
      HANDOVER: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Reset starts with last=2 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      last     <= 2'd2;
      hold     <= '0;
      rd_valid <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last     <= last_n;
      hold     <= hold_n;
      rd_valid <= gnt;
    end
  end

  // Memory mux driven from the registered grant; writes from non-granted
  // requesters never reach the RAM.
  always_comb begin
    mem_addr_a    = '0;
    mem_addr_b    = '0;
    mem_data_in_b = '0;
    mem_we_b      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        mem_addr_a    = rd_addr[i*ADDR_W +: ADDR_W];
        mem_addr_b    = wr_addr[i*ADDR_W +: ADDR_W];
        mem_data_in_b = wr_data[i*DATA_W +: DATA_W];
        mem_we_b      = wr_en[i];
      end
    end
  end

  assign rd_data = mem_data_out_a;

  // Saturating usage counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if ((|gnt) && (busy_cycles != '1))
        busy_cycles <= busy_cycles + CNT_W'(1);
      if (others_pending && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fir_mem_arbiter.sv
// tb_fir_mem_arbiter
// Directed self-checking bench for fir_mem_arbiter (MAX_HOLD = 4) with a
// behavioural dual-port RAM (registered read, 1-cycle latency).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 1-2 time units after the rising edge.
module tb_fir_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          gnt;
  logic [3*ADDR_W-1:0] rd_addr;
  logic [3*ADDR_W-1:0] wr_addr;
  logic [2:0]          wr_en;
  logic [3*DATA_W-1:0] wr_data;
  logic [DATA_W-1:0]   rd_data;
  logic [2:0]          rd_valid;
  logic [ADDR_W-1:0]   mem_addr_a;
  logic [DATA_W-1:0]   mem_data_out_a;
  logic [ADDR_W-1:0]   mem_addr_b;
  logic                mem_we_b;
  logic [DATA_W-1:0]   mem_data_in_b;
  logic [CNT_W-1:0]    busy_cycles;
  logic [CNT_W-1:0]    stall_cycles;

  logic [DATA_W-1:0]   ram [0:(1<<ADDR_W)-1];
  int                  writes_in_reset = 0;
  int                  tests_run = 0;
  int                  tests_failed = 0;

  always #5 clk = ~clk;

  fir_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_addr_a(mem_addr_a), .mem_data_out_a(mem_data_out_a),
    .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_data_in_b(mem_data_in_b),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
  );

  // Behavioural sample RAM; also records any write attempted while in reset.
  always @(posedge clk) begin
    if (mem_we_b) ram[mem_addr_b] <= mem_data_in_b;
    if (mem_we_b && !rst_n) writes_in_reset <= writes_in_reset + 1;
    mem_data_out_a <= ram[mem_addr_a];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) step();
    tests_run++;
    if (gnt !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_gnt got=%b exp=000", gnt); end
    tests_run++;
    if (rd_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_rd_valid got=%b exp=000", rd_valid); end
    tests_run++;
    if (mem_we_b !== 1'b0 || mem_addr_a !== '0) begin tests_failed++; $display("[TB] FAIL reset_mem got we=%b addr_a=%0d exp we=0 addr_a=0", mem_we_b, mem_addr_a); end
    tests_run++;
    if (busy_cycles !== '0 || stall_cycles !== '0) begin tests_failed++; $display("[TB] FAIL reset_counters got busy=%0d stall=%0d exp 0 0", busy_cycles, stall_cycles); end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (gnt !== 3'b000) begin tests_failed++; $display("[TB] FAIL idle_no_req_gnt got=%b exp=000", gnt); end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 3'b001; wr_en = 3'b001;
    step();
    for (int i = 0; i < 5; i++) begin
      wr_addr[0 +: ADDR_W] = ADDR_W'(i);
      wr_data[0 +: DATA_W] = 8'd64;
      if (i == 4) req = 3'b000;
      #1;
      tests_run++;
      if (gnt !== 3'b001 || mem_we_b !== 1'b1 || mem_addr_b !== ADDR_W'(i) || mem_data_in_b !== 8'd64) begin
        tests_failed++;
        $display("[TB] FAIL write_burst[%0d] got gnt=%b we=%b addr_b=%0d data=%0d exp gnt=001 we=1 addr_b=%0d data=64", i, gnt, mem_we_b, mem_addr_b, mem_data_in_b, i);
      end
      step();
    end
    wr_en = 3'b000;
    #1;
    tests_run++;
    if (gnt !== 3'b000 || mem_we_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_handover got gnt=%b we=%b exp 000 0", gnt, mem_we_b); end
    tests_run++;
    if (rd_valid !== 3'b001) begin tests_failed++; $display("[TB] FAIL write_handover_rd_valid got=%b exp=001", rd_valid); end
    tests_run++;
    if (busy_cycles !== 16'd5 || stall_cycles !== 16'd1) begin tests_failed++; $display("[TB] FAIL write_counters got busy=%0d stall=%0d exp busy=5 stall=1", busy_cycles, stall_cycles); end
    step();
    tests_run++;
    if (gnt !== 3'b000 || busy_cycles !== 16'd5) begin tests_failed++; $display("[TB] FAIL write_idle got gnt=%b busy=%0d exp 000 5", gnt, busy_cycles); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ram[i] !== 8'd64) begin tests_failed++; $display("[TB] FAIL ram_contents[%0d] got=%0d exp=64", i, ram[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    logic [2:0] prev_exp;
    do_reset();
    req = 3'b111;
    prev_exp = 3'b000;
    // Each grant: 4 cycles (forced off by the hold limit), then 2 idle cycles.
    for (int c = 1; c <= 22; c++) begin
      step();
      exp_gnt = (((c - 1) % 6) < 4) ? (3'b001 << (((c - 1) / 6) % 3)) : 3'b000;
      tests_run++;
      if (gnt !== exp_gnt) begin tests_failed++; $display("[TB] FAIL rr_gnt[c%0d] got=%b exp=%b", c, gnt, exp_gnt); end
      tests_run++;
      if (rd_valid !== prev_exp) begin tests_failed++; $display("[TB] FAIL rr_rd_valid[c%0d] got=%b exp=%b", c, rd_valid, prev_exp); end
      prev_exp = exp_gnt;
    end
    tests_run++;
    if (stall_cycles !== 16'd22 || busy_cycles !== 16'd15) begin tests_failed++; $display("[TB] FAIL rr_counters got stall=%0d busy=%0d exp stall=22 busy=15", stall_cycles, busy_cycles); end
    req = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_read_return();
    do_reset();
    req = 3'b010;
    rd_addr[ADDR_W +: ADDR_W] = 10'd10;
    step();
    req = 3'b000;
    #1;
    tests_run++;
    if (gnt !== 3'b010 || mem_addr_a !== 10'd10) begin tests_failed++; $display("[TB] FAIL read_issue got gnt=%b addr_a=%0d exp 010 10", gnt, mem_addr_a); end
    step();
    tests_run++;
    if (gnt !== 3'b000) begin tests_failed++; $display("[TB] FAIL read_handover_gnt got=%b exp=000", gnt); end
    tests_run++;
    if (rd_valid !== 3'b010 || rd_data !== 8'd32) begin tests_failed++; $display("[TB] FAIL read_return got rd_valid=%b rd_data=%0d exp 010 32", rd_valid, rd_data); end
    step();
    tests_run++;
    if (rd_valid !== 3'b000) begin tests_failed++; $display("[TB] FAIL read_valid_clear got=%b exp=000", rd_valid); end
    step();
  endtask

  task automatic test_max_hold();
    logic [2:0] exp_gnt;
    do_reset();
    req = 3'b100;
    for (int c = 1; c <= 7; c++) begin
      step();
      exp_gnt = (c <= 4) ? 3'b100 : ((c <= 6) ? 3'b000 : 3'b001);
      tests_run++;
      if (gnt !== exp_gnt) begin tests_failed++; $display("[TB] FAIL hold_forced[c%0d] got=%b exp=%b", c, gnt, exp_gnt); end
      if (c == 2) req = 3'b101;
    end
    do_reset();
    req = 3'b100;
    for (int c = 1; c <= 10; c++) begin
      step();
      tests_run++;
      if (gnt !== 3'b100) begin tests_failed++; $display("[TB] FAIL hold_solo[c%0d] got=%b exp=100", c, gnt); end
    end
    req = 3'b000;
    repeat (3) step();
  endtask

  task automatic test_ignored_write();
    do_reset();
    req = 3'b010;
    rd_addr[ADDR_W +: ADDR_W] = 10'd20;
    wr_addr[0 +: ADDR_W] = 10'd20;
    wr_data[0 +: DATA_W] = 8'hFF;
    wr_addr[ADDR_W +: ADDR_W] = 10'd7;
    wr_data[DATA_W +: DATA_W] = 8'hAA;
    wr_en = 3'b001;
    step();
    req = 3'b000;
    #1;
    tests_run++;
    if (gnt !== 3'b010 || mem_we_b !== 1'b0 || mem_addr_b !== 10'd7) begin tests_failed++; $display("[TB] FAIL ignored_we got gnt=%b we=%b addr_b=%0d exp 010 0 7", gnt, mem_we_b, mem_addr_b); end
    step();
    tests_run++;
    if (rd_valid !== 3'b010 || rd_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL ignored_readback got rd_valid=%b rd_data=%0d exp 010 0", rd_valid, rd_data); end
    tests_run++;
    if (ram[20] !== 8'd0) begin tests_failed++; $display("[TB] FAIL ignored_ram20 got=%0d exp=0", ram[20]); end
    wr_en = 3'b000;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 3'b001; wr_en = 3'b001;
    wr_addr[0 +: ADDR_W] = 10'd100;
    wr_data[0 +: DATA_W] = 8'h55;
    repeat (3) step();
    tests_run++;
    if (gnt !== 3'b001 || mem_we_b !== 1'b1 || busy_cycles !== 16'd2) begin tests_failed++; $display("[TB] FAIL midrst_pre got gnt=%b we=%b busy=%0d exp 001 1 2", gnt, mem_we_b, busy_cycles); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 3'b000 || rd_valid !== 3'b000 || mem_we_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_async got gnt=%b rd_valid=%b we=%b exp 000 000 0", gnt, rd_valid, mem_we_b); end
    tests_run++;
    if (busy_cycles !== '0 || stall_cycles !== '0) begin tests_failed++; $display("[TB] FAIL midrst_counters got busy=%0d stall=%0d exp 0 0", busy_cycles, stall_cycles); end
    repeat (2) step();
    tests_run++;
    if (writes_in_reset !== 0) begin tests_failed++; $display("[TB] FAIL midrst_writes got=%0d exp=0", writes_in_reset); end
    rst_n = 1'b1;
    req = 3'b111; wr_en = 3'b000;
    step();
    tests_run++;
    if (gnt !== 3'b001) begin tests_failed++; $display("[TB] FAIL midrst_first_grant got=%b exp=001", gnt); end
    req = 3'b000;
    repeat (3) step();
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[10] = 8'd32;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_return();
    test_max_hold();
    test_ignored_write();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
